// File: rtl/sram_responder.sv
// SLC-3 external SRAM bus device model: programmable-latency reads, WE-strobed writes, sticky range error.
// Optional SRAM_CLEAR_EN build: an INIT state zero-fills the array after every reset.
module sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned READ_LAT   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_to_SRAM,
  output logic [15:0] Data_from_SRAM,
  output logic        Ready,
  output logic        Addr_Err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_HOLD = 3'd2,
    ST_WR_ACK  = 3'd3
`ifdef SRAM_CLEAR_EN
    , ST_INIT  = 3'd4
`endif
  } state_t;

`ifdef SRAM_CLEAR_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_IDLE;
`endif

  logic [DW-1:0]         r_mem [DEPTH];
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [AW-1:0]         r_addr;
`ifdef SRAM_CLEAR_EN
  logic [DEPTH_LOG2-1:0] r_clr_idx;
`endif

  logic                  w_addr_ok;
  logic                  w_lat_ok;
  logic [DW-1:0]         w_new_data;
  logic [DW-1:0]         w_lat_data;
  logic                  w_busy;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_idx;
  logic [DW-1:0]         w_mem_wdata;

  // In range when every address bit above the implemented depth is zero
  assign w_addr_ok  = (32'(ADDR) >> DEPTH_LOG2) == 32'd0;
  assign w_lat_ok   = (32'(r_addr) >> DEPTH_LOG2) == 32'd0;
  assign w_new_data = w_addr_ok ? r_mem[ADDR[DEPTH_LOG2-1:0]] : DW'(0);
  assign w_lat_data = w_lat_ok ? r_mem[r_addr[DEPTH_LOG2-1:0]] : DW'(0);

`ifdef SRAM_CLEAR_EN
  assign w_busy = (r_state == ST_INIT);
`else
  assign w_busy = 1'b0;
`endif

  // Array write port: one CPU write per WE pulse, or the INIT zero-fill
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = ADDR[DEPTH_LOG2-1:0];
    w_mem_wdata = Data_to_SRAM;
    if (Reset && !WE && !w_busy && (r_state != ST_WR_ACK) && w_addr_ok) begin
      w_mem_we = 1'b1;
    end
`ifdef SRAM_CLEAR_EN
    if (Reset && w_busy) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_clr_idx;
      w_mem_wdata = DW'(0);
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_wdata;
    end
  end

  // Handshake FSM; WE wins over any read in progress
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state        <= RST_STATE;
      r_cnt          <= CNT_W'(0);
      r_addr         <= AW'(0);
      Data_from_SRAM <= DW'(0);
      Ready          <= 1'b0;
      Addr_Err       <= 1'b0;
`ifdef SRAM_CLEAR_EN
      r_clr_idx      <= DEPTH_LOG2'(0);
`endif
    end else begin
      case (r_state)
`ifdef SRAM_CLEAR_EN
        ST_INIT: begin
          r_clr_idx <= r_clr_idx + DEPTH_LOG2'(1);
          if (r_clr_idx == DEPTH_LOG2'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
          end
        end
`endif
        ST_WR_ACK: begin
          if (WE) begin
            r_state <= ST_IDLE;
            Ready   <= 1'b0;
          end
        end
        default: begin
          if (!WE) begin
            r_state <= ST_WR_ACK;
            Ready   <= 1'b1;
            if (!w_addr_ok) begin
              Addr_Err <= 1'b1;
            end
          end else if (r_state == ST_RD_WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (OE) begin
              r_state <= ST_IDLE;
            end else if (r_cnt == CNT_W'(1)) begin
              r_state        <= ST_RD_HOLD;
              Data_from_SRAM <= w_lat_data;
              Ready          <= 1'b1;
            end
          end else if (!OE && ((r_state == ST_IDLE) || (ADDR != r_addr))) begin
            // New read, or a relatch because the address moved under a held OE
            r_addr <= ADDR;
            if (!w_addr_ok) begin
              Addr_Err <= 1'b1;
            end
            if (READ_LAT == 1) begin
              r_state        <= ST_RD_HOLD;
              r_cnt          <= CNT_W'(0);
              Data_from_SRAM <= w_new_data;
              Ready          <= 1'b1;
            end else begin
              r_state <= ST_RD_WAIT;
              r_cnt   <= LAT_M1;
              Ready   <= 1'b0;
            end
          end else if ((r_state == ST_RD_HOLD) && OE) begin
            r_state <= ST_IDLE;
            Ready   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed bus scenarios plus random traffic vs. an array model.
module tb_sram_responder;

  localparam int unsigned DEPTH_LOG2 = 10;
  localparam int unsigned READ_LAT   = 2;
  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [15:0] ADDR;
  logic        OE;
  logic        WE;
  logic [15:0] Data_to_SRAM;
  logic [15:0] Data_from_SRAM;
  logic        Ready;
  logic        Addr_Err;

  sram_responder #(.DEPTH_LOG2(DEPTH_LOG2), .READ_LAT(READ_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .Ready(Ready), .Addr_Err(Addr_Err)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the word array, sticky error and last returned read data
  logic [15:0] m_mem [DEPTH];
  logic        m_err;
  logic [15:0] m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic m_in_range(input logic [15:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [DEPTH_LOG2-1:0] idx;
    idx = a[DEPTH_LOG2-1:0];
    return m_in_range(a) ? m_mem[idx] : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset(input logic we_n);
    Reset = 1'b0;
    OE    = 1'b1;
    WE    = we_n;
    ADDR  = 16'h0005;
    Data_to_SRAM = 16'hDEAD;
    tick();
    check("rst_data", 32'(Data_from_SRAM), 32'h0);
    check("rst_ready", 32'(Ready), 32'h0);
    check("rst_err", 32'(Addr_Err), 32'h0);
    Reset  = 1'b1;
    WE     = 1'b1;
    m_err  = 1'b0;
    m_dout = 16'h0000;
`ifdef SRAM_CLEAR_EN
    WE = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      tick();
      check("init_ready", 32'(Ready), 32'h0);
    end
    WE = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 16'h0000;
`endif
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic both_low);
    ADDR = a;
    Data_to_SRAM = d;
    WE = 1'b0;
    OE = !both_low;
    tick();
    if (m_in_range(a)) m_mem[a[DEPTH_LOG2-1:0]] = d;
    else m_err = 1'b1;
    check("wr_ready", 32'(Ready), 32'h1);
    check("wr_err", 32'(Addr_Err), 32'(m_err));
    WE = 1'b1;
    OE = 1'b1;
    tick();
    check("wr_done_ready", 32'(Ready), 32'h0);
  endtask

  task automatic do_read(input logic [15:0] a);
    ADDR = a;
    OE = 1'b0;
    if (!m_in_range(a)) m_err = 1'b1;
    for (int i = 1; i < int'(READ_LAT); i++) begin
      tick();
      check("rd_wait_ready", 32'(Ready), 32'h0);
      check("rd_wait_hold", 32'(Data_from_SRAM), 32'(m_dout));
    end
    tick();
    m_dout = m_read(a);
    check("rd_ready", 32'(Ready), 32'h1);
    check("rd_data", 32'(Data_from_SRAM), 32'(m_dout));
    check("rd_err", 32'(Addr_Err), 32'(m_err));
    OE = 1'b1;
    tick();
    check("rd_end_ready", 32'(Ready), 32'h0);
    check("rd_end_hold", 32'(Data_from_SRAM), 32'(m_dout));
  endtask

  initial begin
    logic [15:0] a;
    logic [15:0] d;
    Reset = 1'b0;
    OE = 1'b1;
    WE = 1'b1;
    ADDR = 16'h0;
    Data_to_SRAM = 16'h0;
    m_err = 1'b0;
    m_dout = 16'h0;
    do_reset(1'b1);

    // Write then read back
    do_write(16'h0005, 16'h1234, 1'b0);
    do_read(16'h0005);

    // Out-of-range write is dropped, reads as zero, raises the sticky error
    do_write(16'h0405, 16'hBEEF, 1'b0);
    do_read(16'h0405);
    do_read(16'h0005);

    // Simultaneous OE/WE low is a write
    do_write(16'h0010, 16'h00AA, 1'b1);
    do_read(16'h0010);

    // Address moves while OE held: Ready drops, then returns with the new word
    do_write(16'h0006, 16'h6666, 1'b0);
    ADDR = 16'h0005;
    OE = 1'b0;
    repeat (READ_LAT) tick();
    check("hold_ready", 32'(Ready), 32'h1);
    check("hold_data", 32'(Data_from_SRAM), 32'h1234);
    ADDR = 16'h0006;
    tick();
    check("relatch_drop", 32'(Ready), 32'h0);
    check("relatch_hold", 32'(Data_from_SRAM), 32'h1234);
    repeat (READ_LAT - 1) tick();
    check("relatch_ready", 32'(Ready), 32'h1);
    check("relatch_data", 32'(Data_from_SRAM), 32'(m_read(16'h0006)));
    m_dout = m_read(16'h0006);
    OE = 1'b1;
    tick();

    // OE rising during the wait aborts the read and keeps the old data
    ADDR = 16'h0010;
    OE = 1'b0;
    tick();
    OE = 1'b1;
    tick();
    check("abort_ready", 32'(Ready), 32'h0);
    check("abort_hold", 32'(Data_from_SRAM), 32'(m_dout));
    tick();
    check("abort_idle", 32'(Ready), 32'h0);

    // Write pre-empts a held read
    ADDR = 16'h0005;
    OE = 1'b0;
    repeat (READ_LAT) tick();
    m_dout = m_read(16'h0005);
    ADDR = 16'h0007;
    Data_to_SRAM = 16'h7777;
    WE = 1'b0;
    tick();
    m_mem[7] = 16'h7777;
    check("preempt_ready", 32'(Ready), 32'h1);
    WE = 1'b1;
    OE = 1'b1;
    tick();
    do_read(16'h0007);

    // A long WE pulse commits only its first-edge data
    do_write(16'h0021, 16'h5555, 1'b0);
    ADDR = 16'h0020;
    Data_to_SRAM = 16'hA0A0;
    WE = 1'b0;
    tick();
    m_mem[32] = 16'hA0A0;
    ADDR = 16'h0021;
    Data_to_SRAM = 16'hB1B1;
    tick();
    tick();
    check("longwe_ready", 32'(Ready), 32'h1);
    WE = 1'b1;
    tick();
    do_read(16'h0020);
    do_read(16'h0021);

    // Reset mid-read, then a write coinciding with reset is not committed
    ADDR = 16'h0005;
    OE = 1'b0;
    tick();
    do_reset(1'b1);
    do_read(16'h0005);
    do_reset(1'b0);
    do_read(16'h0005);

    // Random traffic over a pre-written window plus occasional out-of-range addresses
    for (int i = 0; i < 32; i++) do_write(16'(i), 16'($urandom), 1'b0);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 65535));
      else a = 16'($urandom_range(0, 31));
      d = 16'($urandom);
      case ($urandom_range(0, 2))
        0: do_write(a, d, 1'b0);
        1: do_write(a, d, 1'b1);
        default: do_read(a);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
